// File: rtl/pht_port_sched.sv
// pht_port_sched: arbitrates one single-ported 2-bit PHT SRAM between fetch-side
// lookups and retire-side counter updates. Updates go into a small in-order write
// buffer that drains on idle cycles, or is forced out when it is full or has been
// starved too long. Lookups that hit the buffer are forwarded. After reset, a
// sweep writes INIT_VAL to every entry before anything else is accepted.
// Optional build macro: PHT_WB_COALESCE_EN (merge updates to an address already buffered).
module pht_port_sched #(
  parameter int unsigned AW         = 14,
  parameter int unsigned WB_DEPTH   = 4,
  parameter int unsigned STARVE_MAX = 8,
  parameter logic [1:0]  INIT_VAL   = 2'b01
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_gnt,
  output logic          rd_valid,
  output logic [1:0]    rd_data,
  input  logic          upd_valid,
  input  logic [AW-1:0] upd_addr,
  input  logic [1:0]    upd_data,
  output logic          upd_ready,
  output logic          pht_en,
  output logic          pht_we,
  output logic [AW-1:0] pht_addr,
  output logic [1:0]    pht_wdata,
  input  logic [1:0]    pht_rdata,
  output logic          init_busy
);

  localparam int unsigned PW = $clog2(WB_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e        state_q;
  logic [AW-1:0] ptr_q;
  logic [AW-1:0] wb_addr_q [WB_DEPTH];
  logic [1:0]    wb_data_q [WB_DEPTH];
  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q;
  logic [SW-1:0] starve_q;
  logic          rd_valid_q, fwd_hit_q;
  logic [1:0]    rd_data_q;

  logic          wb_empty, wb_full, force_wr;
  logic          do_wr, do_rd, do_enq, upd_acc;
  logic          fwd_hit;
  logic [1:0]    fwd_data;
  logic          co_hit;

  assign wb_empty = (count_q == '0);
  assign wb_full  = (count_q == CW'(WB_DEPTH));
  assign force_wr = wb_full | (starve_q == SW'(STARVE_MAX));

  // Port arbitration: forced drain beats reads, reads beat opportunistic drain.
  always_comb begin
    do_wr = 1'b0;
    do_rd = 1'b0;
    if (state_q == StRun) begin
      if (!wb_empty && (force_wr || !rd_req)) begin
        do_wr = 1'b1;
      end else if (rd_req) begin
        do_rd = 1'b1;
      end
    end
  end

  // Forwarding lookup over entries valid at cycle start; youngest match wins.
  always_comb begin
    logic [PW-1:0] slot;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int unsigned i = 0; i < WB_DEPTH; i++) begin
      slot = head_q + PW'(i);
      if ((CW'(i) < count_q) && (wb_addr_q[slot] == rd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = wb_data_q[slot];
      end
    end
  end

`ifdef PHT_WB_COALESCE_EN
  logic [PW-1:0] co_slot;

  // Coalesce target: a buffered entry with the same address that is not leaving this cycle.
  always_comb begin
    logic [PW-1:0] slot;
    co_hit  = 1'b0;
    co_slot = '0;
    for (int unsigned i = 0; i < WB_DEPTH; i++) begin
      slot = head_q + PW'(i);
      if ((CW'(i) < count_q) && !(do_wr && (i == 0)) && (wb_addr_q[slot] == upd_addr)) begin
        co_hit  = 1'b1;
        co_slot = slot;
      end
    end
  end

  assign upd_ready = (state_q == StRun) && (!wb_full || co_hit);
`else
  assign co_hit    = 1'b0;
  assign upd_ready = (state_q == StRun) && !wb_full;
`endif

  assign upd_acc = upd_valid & upd_ready;
  assign do_enq  = upd_acc & ~co_hit;

  // SRAM command: sweep writes in INIT, otherwise the arbitration winner.
  always_comb begin
    pht_en    = 1'b0;
    pht_we    = 1'b0;
    pht_addr  = rd_addr;
    pht_wdata = wb_data_q[head_q];
    if (state_q == StInit) begin
      pht_en    = 1'b1;
      pht_we    = 1'b1;
      pht_addr  = ptr_q;
      pht_wdata = INIT_VAL;
    end else if (do_wr) begin
      pht_en   = 1'b1;
      pht_we   = 1'b1;
      pht_addr = wb_addr_q[head_q];
    end else if (do_rd) begin
      pht_en = 1'b1;
    end
  end

  assign rd_gnt    = do_rd;
  assign init_busy = (state_q == StInit);
  assign rd_valid  = rd_valid_q;
  // Non-forwarded reads take the SRAM output directly in the return cycle.
  assign rd_data   = (rd_valid_q && !fwd_hit_q) ? pht_rdata : rd_data_q;

  // Init/run FSM with the sweep pointer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StInit;
      ptr_q   <= '0;
    end else if (state_q == StInit) begin
      ptr_q <= ptr_q + AW'(1);
      if (ptr_q == {AW{1'b1}}) begin
        state_q <= StRun;
      end
    end
  end

  // Write-buffer occupancy, pointers and starvation counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      starve_q <= '0;
    end else begin
      if (do_wr) begin
        head_q <= head_q + PW'(1);
      end
      if (do_enq) begin
        tail_q <= tail_q + PW'(1);
      end
      unique case ({do_enq, do_wr})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (do_wr) begin
        starve_q <= '0;
      end else if ((state_q == StRun) && !wb_empty && (starve_q != SW'(STARVE_MAX))) begin
        starve_q <= starve_q + SW'(1);
      end
    end
  end

  // Write-buffer storage; validity is tracked by the pointers, so no reset needed.
  always_ff @(posedge clk) begin
    if (do_enq) begin
      wb_addr_q[tail_q] <= upd_addr;
      wb_data_q[tail_q] <= upd_data;
    end
`ifdef PHT_WB_COALESCE_EN
    if (upd_acc && co_hit) begin
      wb_data_q[co_slot] <= upd_data;
    end
`endif
  end

  // Read return pipeline; rd_data_q holds the last returned value.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_valid_q <= 1'b0;
      fwd_hit_q  <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= do_rd;
      fwd_hit_q  <= do_rd & fwd_hit;
      if (do_rd && fwd_hit) begin
        rd_data_q <= fwd_data;
      end else if (rd_valid_q && !fwd_hit_q) begin
        rd_data_q <= pht_rdata;
      end
    end
  end

endmodule
